instr_fetch_ctrl: RTL and testbench

//   Fetch sequencer for the synchronous instruction ROM (1-cycle read latency).

---
 rtl/instr_fetch_ctrl.sv | 140 ++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_ctrl
// Description : Fetch sequencer for a synchronous instruction ROM with a
//               one-cycle read latency. It owns the fetch PC, issues ROM
//               reads, tracks the single in-flight read and captures the
//               returned words into a small prefetch FIFO. The FIFO delivers
//               {pc, instr} pairs to decode over a valid/ready handshake.
//               Redirects flush stale work; halt blocks new reads only.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                in   clock, rising edge
//   rst_n              in   asynchronous active-low reset
//   o_mem_addr         out  ROM byte address (redirect target or fetch PC)
//   o_mem_rd           out  a read of o_mem_addr is issued this cycle
//   i_mem_instr        in   ROM data, valid the cycle after the issue
//   i_redirect_valid   in   single-cycle redirect request
//   i_redirect_pc      in   redirect target
//   i_halt             in   level; blocks issue of new reads
//   o_out_valid        out  FIFO head holds a valid entry
//   i_out_ready        in   decode accepts the head entry
//   o_out_pc           out  PC of the head entry
//   o_out_instr        out  instruction of the head entry
//   o_halted           out  halt requested, nothing in flight, FIFO empty
// ============================================================================
module instr_fetch_ctrl #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0,
    parameter int                         DEPTH         = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [ADDRESS_WIDTH-1:0]   o_mem_addr,
    output logic                       o_mem_rd,
    input  logic [DATA_WIDTH-1:0]      i_mem_instr,
    input  logic                       i_redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0]   i_redirect_pc,
    input  logic                       i_halt,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [ADDRESS_WIDTH-1:0]   o_out_pc,
    output logic [DATA_WIDTH-1:0]      o_out_instr,
    output logic                       o_halted
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    // One extra bit so count + inflight never overflows the comparison.
    localparam int c_OCC_W = c_CNT_W + 1;

    logic [ADDRESS_WIDTH-1:0] r_fetch_pc;
    logic                     r_inflight;
    logic [ADDRESS_WIDTH-1:0] r_inflight_pc;
    logic [c_CNT_W-1:0]       r_count;
    logic [c_PTR_W-1:0]       r_wr_ptr;
    logic [c_PTR_W-1:0]       r_rd_ptr;
    logic [ADDRESS_WIDTH-1:0] r_fifo_pc    [DEPTH];
    logic [DATA_WIDTH-1:0]    r_fifo_instr [DEPTH];

    logic                     w_pop;
    logic                     w_push;
    logic [c_OCC_W-1:0]       w_occupancy;
    logic                     w_space;

    assign o_out_valid = (r_count != '0);
    assign o_out_pc    = r_fifo_pc[r_rd_ptr];
    assign o_out_instr = r_fifo_instr[r_rd_ptr];
    assign w_pop       = o_out_valid & i_out_ready;

    // Slots already committed (stored + in flight) after this cycle's pop.
    // A pop implies count >= 1, so the subtraction cannot underflow.
    assign w_occupancy = {1'b0, r_count} + c_OCC_W'(r_inflight) - c_OCC_W'(w_pop);
    assign w_space     = (w_occupancy < c_OCC_W'(DEPTH));

    // Gated by rst_n so no read is ever issued while reset is held.
    assign o_mem_rd    = rst_n & ~i_halt & w_space;
    assign o_mem_addr  = i_redirect_valid ? i_redirect_pc : r_fetch_pc;

    // A response that lands in a redirect cycle belongs to the old path.
    assign w_push      = r_inflight & ~i_redirect_valid;

    assign o_halted    = i_halt & ~r_inflight & (r_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_pc[i]    <= '0;
                r_fifo_instr[i] <= '0;
            end
        end else begin
            // Issue tracking and PC sequencing (+4 wraps naturally).
            if (o_mem_rd) begin
                r_inflight    <= 1'b1;
                r_inflight_pc <= o_mem_addr;
                r_fetch_pc    <= o_mem_addr + ADDRESS_WIDTH'(4);
            end else begin
                r_inflight <= 1'b0;
                if (i_redirect_valid) begin
                    r_fetch_pc <= i_redirect_pc;
                end
            end

            // Returned ROM word is captured straight from the bus.
            if (w_push) begin
                r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
                r_fifo_instr[r_wr_ptr] <= i_mem_instr;
            end

            // Flush on redirect; a pop in the same cycle has already been
            // handed to decode, so simply discarding the rest is correct.
            if (i_redirect_valid) begin
                r_count  <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_ctrl
// Description : Directed self-checking bench for instr_fetch_ctrl with a
//               one-cycle-latency ROM model where ROM[k] = k + 0x100.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        halted;

    int checks = 0;
    int errors = 0;

    instr_fetch_ctrl #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .RESET_PC      (32'h0),
        .DEPTH         (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .o_mem_addr       (mem_addr),
        .o_mem_rd         (mem_rd),
        .i_mem_instr      (mem_instr),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .i_halt           (halt),
        .o_out_valid      (out_valid),
        .i_out_ready      (out_ready),
        .o_out_pc         (out_pc),
        .o_out_instr      (out_instr),
        .o_halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: word index k holds k + 0x100.
    always @(posedge clk) begin
        if (mem_rd) mem_instr <= (mem_addr >> 2) + 32'h100;
    end

    // Occupancy must never exceed DEPTH.
    always @(negedge clk) begin
        if (rst_n && dut.r_count > 2) begin
            errors++;
            $display("FAIL occupancy: count=%0d limit=2", dut.r_count);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        out_ready      = 1'b1;
    endtask

    // Reset, release, and advance to the first cycle with out_valid=1.
    task automatic restart();
        rst_n = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", out_pc); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", out_instr); end
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL rst_mem_rd: got %b want 0", mem_rd); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        rst_n = 1'b1;
        #1;
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL first_issue: rd=%b addr=%h want rd=1 addr=0", mem_rd, mem_addr); end
        cyc();
        #1;
        checks++; if (out_valid !== 1'b0 || mem_addr !== 32'h4) begin errors++; $display("FAIL cycle2: valid=%b addr=%h want valid=0 addr=4", out_valid, mem_addr); end
        cyc();
        #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h100) begin
            errors++; $display("FAIL cycle3: valid=%b pc=%h instr=%h want 1/0/100", out_valid, out_pc, out_instr); end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 8; i++) begin
            cyc();
            #1;
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4*i) || out_instr !== 32'(32'h100 + i)) begin
                errors++; $display("FAIL stream[%0d]: valid=%b pc=%h instr=%h want 1/%h/%h", i, out_valid, out_pc, out_instr, 32'(4*i), 32'(32'h100 + i)); end
        end
    endtask

    task automatic test_backpressure();
        restart();
        out_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
            #1;
            checks++; if (mem_rd !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h0 || mem_addr !== 32'h8) begin
                errors++; $display("FAIL stall[%0d]: rd=%b valid=%b pc=%h addr=%h want 0/1/0/8", s, mem_rd, out_valid, out_pc, mem_addr); end
            cyc();
        end
        checks++; if (dut.r_count !== 2'd2) begin errors++; $display("FAIL stall_count: got %0d want 2", dut.r_count); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4*i) || out_instr !== 32'(32'h100 + i)) begin
                errors++; $display("FAIL resume[%0d]: valid=%b pc=%h instr=%h want 1/%h/%h", i, out_valid, out_pc, out_instr, 32'(4*i), 32'(32'h100 + i)); end
            cyc();
        end
    endtask

    task automatic test_redirect();
        restart();
        #1;
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL redir_pre: pc=%h want 0", out_pc); end
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #1;
        checks++; if (out_pc !== 32'h4 || mem_addr !== 32'h40 || mem_rd !== 1'b1) begin
            errors++; $display("FAIL redir_cycle: pc=%h addr=%h rd=%b want 4/40/1", out_pc, mem_addr, mem_rd); end
        cyc();
        redirect_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_n1: valid=%b want 0", out_valid); end
        cyc();
        #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== 32'h110) begin
            errors++; $display("FAIL redir_n2: valid=%b pc=%h instr=%h want 1/40/110", out_valid, out_pc, out_instr); end
        cyc();
        #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h44 || out_instr !== 32'h111) begin
            errors++; $display("FAIL redir_n3: valid=%b pc=%h instr=%h want 1/44/111", out_valid, out_pc, out_instr); end
    endtask

    task automatic test_redirect_pop();
        restart();
        out_ready = 1'b0;
        cyc();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || mem_rd !== 1'b1 || mem_addr !== 32'h80) begin
            errors++; $display("FAIL rpop_cycle: valid=%b pc=%h rd=%b addr=%h want 1/0/1/80", out_valid, out_pc, mem_rd, mem_addr); end
        cyc();
        redirect_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rpop_empty: valid=%b want 0", out_valid); end
        cyc();
        #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h80 || out_instr !== 32'h120) begin
            errors++; $display("FAIL rpop_target: valid=%b pc=%h instr=%h want 1/80/120", out_valid, out_pc, out_instr); end
    endtask

    task automatic test_halt();
        restart();
        halt = 1'b1;
        #1;
        checks++; if (mem_rd !== 1'b0 || halted !== 1'b0 || out_pc !== 32'h0) begin
            errors++; $display("FAIL halt_c0: rd=%b halted=%b pc=%h want 0/0/0", mem_rd, halted, out_pc); end
        cyc();
        #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4 || halted !== 1'b0) begin
            errors++; $display("FAIL halt_c1: valid=%b pc=%h halted=%b want 1/4/0", out_valid, out_pc, halted); end
        cyc();
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++; if (out_valid !== 1'b0 || halted !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 32'h8) begin
                errors++; $display("FAIL halted[%0d]: valid=%b halted=%b rd=%b addr=%h want 0/1/0/8", s, out_valid, halted, mem_rd, mem_addr); end
            cyc();
        end
        halt = 1'b0;
        #1;
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 32'h8 || halted !== 1'b0) begin
            errors++; $display("FAIL unhalt: rd=%b addr=%h halted=%b want 1/8/0", mem_rd, mem_addr, halted); end
        cyc();
        cyc();
        #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instr !== 32'h102) begin
            errors++; $display("FAIL resume_pc: valid=%b pc=%h instr=%h want 1/8/102", out_valid, out_pc, out_instr); end
        cyc();
        #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'hC || out_instr !== 32'h103) begin
            errors++; $display("FAIL resume_pc2: valid=%b pc=%h instr=%h want 1/c/103", out_valid, out_pc, out_instr); end
    endtask

    task automatic test_reset_midstream();
        restart();
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || mem_rd !== 1'b0) begin
            errors++; $display("FAIL async_rst: valid=%b pc=%h instr=%h rd=%b want all 0", out_valid, out_pc, out_instr, mem_rd); end
        cyc();
        rst_n          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        #1;
        checks++; if (mem_addr !== 32'hFFFF_FFFC || mem_rd !== 1'b1) begin
            errors++; $display("FAIL wrap_issue: addr=%h rd=%b want fffffffc/1", mem_addr, mem_rd); end
        cyc();
        redirect_valid = 1'b0;
        #1;
        checks++; if (mem_addr !== 32'h0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_next: addr=%h valid=%b want 0/0", mem_addr, out_valid); end
        cyc();
        #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_instr !== 32'h4000_00FF) begin
            errors++; $display("FAIL wrap_top: valid=%b pc=%h instr=%h want 1/fffffffc/400000ff", out_valid, out_pc, out_instr); end
        cyc();
        #1;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h100) begin
            errors++; $display("FAIL wrap_zero: valid=%b pc=%h instr=%h want 1/0/100", out_valid, out_pc, out_instr); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_halt();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
